// File: rtl/spi_pkg.sv
// Shared definitions for the SPI blocks: frame-state encoding and default word length.
package spi_pkg;

   localparam int unsigned SPI_DATA_W = 16;

   typedef enum logic [1:0] {
      DONE,
      IDLE,
      SHIFT
   } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// Single-bit multi-flop synchronizer with a configurable reset value.
module spi_sync #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   // Shift the asynchronous input through STAGES flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ff <= {STAGES{RST_VAL}};
      else          ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_slave_sync.sv
// SPI mode-0 slave oversampled on clk. One word per chip-select frame, MSB first.
// Optional feature: define SPI_SLAVE_MISO_OE_EN to add the spi_miso_oe output.
module spi_slave_sync
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W      = SPI_DATA_W,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              spi_cs_l,
   input  logic              spi_sclk,
   input  logic              spi_mosi,
   output logic              spi_miso,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              frame_err
`ifdef SPI_SLAVE_MISO_OE_EN
   ,output logic             spi_miso_oe
`endif
);

   localparam int unsigned CNT_W = $clog2(DATA_W + 1);

   spi_state_t        state, state_nx;
   logic              cs_s, sclk_s, mosi_s;
   logic              cs_d, sclk_d;
   logic [SYNC_STAGES-1:0] prime;
   logic              sync_ok;
   logic              cs_fall, cs_rise, sclk_rise, sclk_fall;
   logic              frame_start, frame_done, frame_abort, accept;
   logic [DATA_W-1:0] tx_buf, tx_sh, rx_sh;
   logic              tx_full;
   logic [CNT_W-1:0]  bit_cnt;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .reset_n(reset_n), .d(spi_cs_l), .q(cs_s));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .reset_n(reset_n), .d(spi_sclk), .q(sclk_s));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .reset_n(reset_n), .d(spi_mosi), .q(mosi_s));

   // Delayed copies for edge detection; prime marks when the synchronizers
   // hold real pin samples rather than their reset values, so a cs held low
   // across reset release cannot look like a high-then-low sequence.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cs_d   <= 1'b1;
         sclk_d <= 1'b0;
         prime  <= '0;
      end else begin
         cs_d   <= cs_s;
         sclk_d <= sclk_s;
         prime  <= {prime[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign sync_ok     = prime[SYNC_STAGES-1];
   assign cs_fall     = cs_d & ~cs_s;
   assign cs_rise     = ~cs_d & cs_s;
   assign sclk_rise   = ~sclk_d & sclk_s;
   assign sclk_fall   = sclk_d & ~sclk_s;
   assign frame_start = (state == IDLE) && cs_fall;
   assign frame_done  = (state == SHIFT) && (bit_cnt == CNT_W'(DATA_W));
   assign frame_abort = (state == SHIFT) && !frame_done && cs_rise;
   assign accept      = tx_valid && !tx_full;
   assign tx_ready    = ~tx_full;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= DONE;
      else          state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      unique case (state)
         DONE:    if (sync_ok && cs_s) state_nx = IDLE;
         IDLE:    if (cs_fall)         state_nx = SHIFT;
         SHIFT: begin
            if (frame_done)   state_nx = DONE;
            else if (cs_rise) state_nx = IDLE;
         end
         default: state_nx = DONE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      busy     = (state == SHIFT);
      spi_miso = busy & tx_sh[DATA_W-1];
`ifdef SPI_SLAVE_MISO_OE_EN
      spi_miso_oe = busy;
`endif
   end

   // Transmit buffer, shifters, bit counter and received-word strobes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_buf    <= '0;
         tx_full   <= 1'b0;
         tx_sh     <= '0;
         rx_sh     <= '0;
         bit_cnt   <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_valid  <= frame_done;
         frame_err <= frame_abort;
         if (frame_done) rx_data <= rx_sh;

         // Accept has priority over the start-of-frame clear: a word accepted
         // in the start cycle stays buffered for the following frame.
         if (accept) begin
            tx_buf  <= tx_data;
            tx_full <= 1'b1;
         end else if (frame_start) begin
            tx_full <= 1'b0;
         end

         if (frame_start) begin
            tx_sh   <= tx_full ? tx_buf : '0;
            rx_sh   <= '0;
            bit_cnt <= '0;
         end else if (state == SHIFT && bit_cnt < CNT_W'(DATA_W)) begin
            if (sclk_rise) begin
               rx_sh   <= {rx_sh[DATA_W-2:0], mosi_s};
               bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (sclk_fall) tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed + randomized bench for spi_slave_sync acting as a mode-0 SPI master.
module tb_spi_slave_sync;

   localparam int DW = 16;
   localparam int H  = 6;   // clk cycles per sclk phase

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          spi_cs_l = 1'b1;
   logic          spi_sclk = 1'b0;
   logic          spi_mosi = 1'b0;
   logic          spi_miso;
   logic [DW-1:0] tx_data = '0;
   logic          tx_valid = 1'b0;
   logic          tx_ready;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          busy;
   logic          frame_err;
`ifdef SPI_SLAVE_MISO_OE_EN
   logic          spi_miso_oe;
`endif

   spi_slave_sync #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset_n(reset_n), .spi_cs_l(spi_cs_l), .spi_sclk(spi_sclk),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
      .rx_valid(rx_valid), .busy(busy), .frame_err(frame_err)
`ifdef SPI_SLAVE_MISO_OE_EN
      , .spi_miso_oe(spi_miso_oe)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int rxv_cnt = 0, ferr_cnt = 0, rxv_cyc = 0;
   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         rxv_cnt++;
         rxv_cyc = cyc;
      end
      if (frame_err === 1'b1) ferr_cnt++;
   end

   int checks = 0, errors = 0;

   // Reference model state: one-word transmit buffer and last received word.
   logic [DW-1:0] m_buf = '0;
   bit            m_full = 0;
   logic [DW-1:0] m_rx = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input logic [DW-1:0] w);
      int t = 0;
      while (tx_ready !== 1'b1 && t < 200) begin
         tick(1);
         t++;
      end
      check("load_ready", {31'd0, tx_ready}, 32'd1);
      tx_data  = w;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
      m_buf  = w;
      m_full = 1;
      check("tx_ready_low_after_accept", {31'd0, tx_ready}, 32'd0);
   endtask

   // Master frame: nclk sclk pulses; optional accept of acc_w during bit 4.
   task automatic frame(input logic [DW-1:0] mw, input int nclk,
                        input bit mid_acc, input logic [DW-1:0] acc_w);
      logic [DW-1:0] exp_miso, got_miso;
      int rxv0, fe0, rise_last;
      exp_miso  = m_full ? m_buf : '0;
      got_miso  = '0;
      rise_last = 0;
      check("tx_ready_before_start", {31'd0, tx_ready}, {31'd0, !m_full});
      m_full = 0;
      rxv0 = rxv_cnt;
      fe0  = ferr_cnt;
      spi_cs_l = 1'b0;
      spi_mosi = mw[DW-1];
      tick(H);
      for (int i = 0; i < nclk; i++) begin
         if (i == 0) begin
            check("tx_ready_after_start", {31'd0, tx_ready}, 32'd1);
            check("busy_in_frame", {31'd0, busy}, 32'd1);
         end
         if (i < DW) got_miso[DW-1-i] = spi_miso;
         else begin
            check("miso_after_last_bit", {31'd0, spi_miso}, 32'd0);
            check("busy_after_last_bit", {31'd0, busy}, 32'd0);
         end
`ifdef SPI_SLAVE_MISO_OE_EN
         check("miso_oe", {31'd0, spi_miso_oe}, {31'd0, (i < DW)});
`endif
         spi_sclk = 1'b1;
         if (i == DW - 1) rise_last = cyc;
         if (mid_acc && i == 4) begin
            tx_data  = acc_w;
            tx_valid = 1'b1;
            tick(1);
            tx_valid = 1'b0;
            m_buf  = acc_w;
            m_full = 1;
            tick(H - 1);
         end else begin
            tick(H);
         end
         spi_sclk = 1'b0;
         spi_mosi = (i + 1 < DW) ? mw[DW-2-i] : 1'($urandom);
         tick(H);
      end
      spi_cs_l = 1'b1;
      tick(10);
      check("busy_idle", {31'd0, busy}, 32'd0);
      check("miso_idle", {31'd0, spi_miso}, 32'd0);
`ifdef SPI_SLAVE_MISO_OE_EN
      check("miso_oe_idle", {31'd0, spi_miso_oe}, 32'd0);
`endif
      if (nclk >= DW) begin
         check("rx_valid_pulses", rxv_cnt - rxv0, 32'd1);
         check("frame_err_none", ferr_cnt - fe0, 32'd0);
         check("rx_valid_latency", rxv_cyc - rise_last, 32'd4);
         check("rx_data", {16'd0, rx_data}, {16'd0, mw});
         check("master_rx", {16'd0, got_miso}, {16'd0, exp_miso});
         m_rx = mw;
      end else begin
         check("abort_no_rx_valid", rxv_cnt - rxv0, 32'd0);
         check("abort_frame_err", ferr_cnt - fe0, 32'd1);
         check("abort_rx_data_kept", {16'd0, rx_data}, {16'd0, m_rx});
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int fe0, rxv0;
      // Reset values
      tick(3);
      check("rst_miso", {31'd0, spi_miso}, 32'd0);
      check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
      check("rst_rx_data", {16'd0, rx_data}, 32'd0);
      check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      reset_n = 1'b1;
      tick(8);

      // Loaded word exchange
      load(16'h5A3C);
      frame(16'hA5F0, 16, 0, '0);

      // Nothing loaded: slave sends zeros
      frame(16'h1234, 16, 0, '0);

      // Aborted frame, then a correct one
      frame(16'($urandom), 8, 0, '0);
      frame(16'($urandom), 16, 0, '0);

      // Extra sclk pulses beyond the word length
      load(16'($urandom));
      frame(16'($urandom), 20, 0, '0);

      // Reset in the middle of a frame with cs held low
      load(16'h7E81);
      spi_cs_l = 1'b0;
      spi_mosi = 1'b1;
      tick(H);
      for (int i = 0; i < 5; i++) begin
         spi_sclk = 1'b1; tick(H);
         spi_sclk = 1'b0; tick(H);
      end
      reset_n = 1'b0;
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_miso", {31'd0, spi_miso}, 32'd0);
      check("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
      check("midrst_rx_data", {16'd0, rx_data}, 32'd0);
      m_full = 0;
      m_rx   = '0;
      tick(2);
      reset_n = 1'b1;
      fe0  = ferr_cnt;
      rxv0 = rxv_cnt;
      tick(H);
      for (int i = 0; i < DW; i++) begin
         spi_mosi = 1'($urandom);
         spi_sclk = 1'b1; tick(H);
         if (i == 0 || i == DW - 1) begin
            check("postrst_busy", {31'd0, busy}, 32'd0);
            check("postrst_miso", {31'd0, spi_miso}, 32'd0);
         end
         spi_sclk = 1'b0; tick(H);
      end
      spi_cs_l = 1'b1;
      tick(10);
      check("postrst_no_rx_valid", rxv_cnt - rxv0, 32'd0);
      check("postrst_no_frame_err", ferr_cnt - fe0, 32'd0);
      check("postrst_rx_data", {16'd0, rx_data}, 32'd0);
      frame(16'($urandom), 16, 0, '0);

      // Accept during a frame: held for the next one
      load(16'hCAFE);
      frame(16'($urandom), 16, 1, 16'hBEEF);
      check("held_word_ready_low", {31'd0, tx_ready}, 32'd0);
      frame(16'($urandom), 16, 0, '0);

      // Randomized frames
      for (int k = 0; k < 4; k++) begin
         if ($urandom_range(1, 0) == 1) load(16'($urandom));
         frame(16'($urandom), 16, 0, '0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_slave_sync.md
# spi_slave_sync

Clock-domain SPI slave (mode 0: CPOL=0, CPHA=0, MSB first, one word per chip-select frame). It oversamples the SPI pins on the system clock `clk` through synchronizers, then shifts MOSI in and MISO out. Toward the host it offers a one-word transmit buffer with a ready/valid handshake and a received-word strobe. It is the fully synchronous responder for the existing SPI initiator (`spi_state`) and plugs onto the same `spi_cs_l`/`spi_sclk`/`spi_mosi`/`spi_miso` lines.

## Interface
- `DATA_W`, 16: frame/word length in bits.
- `SYNC_STAGES`, 2: flip-flop depth of each pin synchronizer (≥2).
- `clk` in 1: system clock; the only clock in the block.
- `reset_n` in 1: asynchronous, active-low reset.
- `spi_cs_l` in 1: chip select, active low.
- `spi_sclk` in 1: SPI clock from the initiator.
- `spi_mosi` in 1: initiator-to-slave data.
- `spi_miso` out 1: slave-to-initiator data.
- `tx_data` in DATA_W: word to send in the next frame.
- `tx_valid` in 1: `tx_data` offered.
- `tx_ready` out 1: transmit buffer empty; word accepted when `tx_valid && tx_ready`.
- `rx_data` out DATA_W: last complete received word; held until the next completion.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `busy` out 1: frame in progress (state SHIFT).
- `frame_err` out 1: one-cycle pulse when a frame is aborted early.

## Operation
- `spi_cs_l`, `spi_sclk` and `spi_mosi` each pass through SYNC_STAGES flops. Synchronizer reset values: cs 1, sclk 0, mosi 0.
- Edge detect compares the synced value with a one-flop delayed copy.
- Transmit buffer: `tx_ready` = buffer empty. An accept writes the buffer and sets it full. Frame start copies the buffer to the tx shifter and empties it.
- If frame start and an accept fall in the same cycle, the frame uses the buffer content from before that cycle. The accepted word is held for the next frame.
- States:
  - DONE (reset state): waits for synced cs high, then → IDLE.
  - IDLE: on synced cs falling edge → SHIFT. Loads the tx shifter with the buffer if full, else all-zeros. Clears bit_cnt and the rx shifter.
  - SHIFT:
    - sclk rise: rx shifter ← {rx[DATA_W-2:0], mosi_sync}; bit_cnt++.
    - sclk fall: tx shifter shifts left.
    - When bit_cnt reaches DATA_W: `rx_data` ← rx shifter, `rx_valid` pulses, → DONE.
    - Synced cs rise before DATA_W bits: `frame_err` pulses, `rx_data` unchanged, → IDLE.
- `spi_miso` = tx shifter MSB in SHIFT; 0 in IDLE/DONE.
- sclk edges outside SHIFT are ignored, including extra clocks after DATA_W bits.
- bit_cnt width is $clog2(DATA_W+1); it never wraps.

## Timing
- Reset values: `spi_miso` 0, `tx_ready` 1, `rx_data` 0, `rx_valid` 0, `busy` 0, `frame_err` 0; state DONE.
- Pin-to-action latency: SYNC_STAGES+1 clk cycles from a pin edge to the register update it causes.
- `spi_miso` changes SYNC_STAGES+1 cycles after the pin sclk fall. The first bit appears SYNC_STAGES+1 cycles after the pin cs fall.
- `rx_valid` is high in cycle SYNC_STAGES+2 after the DATA_W-th pin sclk rise.
- `tx_ready` returns high the cycle after frame start.
- Legal SPI rate: sclk high and low phases, and cs-fall-to-first-sclk-rise, each ≥ SYNC_STAGES+2 clk periods.
- Reset mid-frame: everything clears immediately. If cs is still low at release, no frame starts until cs is seen high and then low again.

## Configuration
- `SPI_SLAVE_MISO_OE_EN` defined: adds output port `spi_miso_oe` (1 bit, reset 0), which is high only in SHIFT. The pad tristates MISO when it is low.
- Not defined: no `spi_miso_oe` port; `spi_miso` is driven 0 outside SHIFT.

## Structure
- Shared package `spi_pkg`: state enum (DONE, IDLE, SHIFT) and the default `SPI_DATA_W = 16` constant.
- One sub-module, `spi_sync`: a SYNC_STAGES-deep single-bit synchronizer with a reset-value parameter, instanced three times.

## Test plan
- Load 16'h5A3C via tx handshake, then a bench mode-0 master sends 16'hA5F0 → `rx_data`=A5F0 with a single `rx_valid` pulse; master captures 5A3C; `tx_ready` low until frame start.
- No word loaded; master sends 16'h1234 → master receives 16'h0000; `rx_data`=1234.
- cs rises after 8 sclk → `frame_err` pulses once; no `rx_valid`; `rx_data` keeps its old value; the next full frame is received correctly.
- 20 sclk pulses in one frame → exactly one `rx_valid` after the 16th rise; MISO 0 after bit 16.
- `reset_n` pulsed low at bit 5 with cs held low → outputs take reset values; sclk ignored until cs goes high, then low; the following frame is correct.
- Accept 16'hBEEF during a frame that sends 16'hCAFE → CAFE goes out now, BEEF in the next frame; with the macro defined, `spi_miso_oe` tracks `busy`.
